dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, number of 16-bit data RAM words.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clocks per UART bit (minimum 2).
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port daddr, input, 16, byte address from the core; bit 0 ignored.
REQ-006 SHALL have port ddout, input, 16, store data from the core.
REQ-007 SHALL have port doe, input, 1, load strobe.
REQ-008 SHALL have port dwe, input, 1, store strobe.
REQ-009 SHALL have port ddin, output, 16, load data to the core.
REQ-010 SHALL have port gpio_out, output, 16, GPIO output register.
REQ-011 SHALL have port uart_tx, output, 1, serial transmit line, idle high.
REQ-012 SHALL have port irq, output, 1, equal to the timer match sticky flag.

Function
REQ-013 SHALL decode this word map: RAM at 0x0000 to 2*RAM_WORDS-2; GPIO 0xFF00 (R/W); TIMER 0xFF02 (R/W); CMP 0xFF04 (R/W); STATUS 0xFF06 (bit0 = match, write-1-to-clear); UTX 0xFF08 (write only); USTAT 0xFF0A (bit0 = busy, read only).
REQ-014 SHALL drive ddin combinationally from daddr in the same cycle when doe=1 and dwe=0, with zero added latency (the core samples it in the same cycle).
REQ-015 SHALL drive ddin=0x0000 when doe=0, when dwe=1, for unmapped addresses, and for UTX.
REQ-016 SHALL perform writes at the clock edge ending the cycle where dwe=1; doe is ignored while dwe=1.
REQ-017 SHALL silently drop writes to unmapped addresses and to USTAT.
REQ-018 SHALL make a RAM write visible to a load in the following cycle (write-then-read, no bypass needed in the same cycle).
REQ-019 SHALL increment TIMER by 1 every cycle, wrapping 0xFFFF to 0x0000.
REQ-020 SHALL load a write to TIMER as written, with no increment in that cycle.
REQ-021 SHALL set STATUS.match in the cycle after TIMER==CMP; a same-cycle set and W1C clear SHALL leave it set.
REQ-022 SHALL start a UART frame on a UTX write while busy=0, latching ddout[7:0].
REQ-023 SHALL ignore a UTX write while busy=1, with no effect on the frame in flight.
REQ-024 SHALL run the UART FSM IDLE->START->DATA->STOP->IDLE, with each bit held CLKS_PER_BIT cycles, data sent LSB first, 8 bits, and stop bit = 1.
REQ-025 SHALL drive uart_tx low and set busy=1 from the cycle after an accepted write.
REQ-026 SHALL clear busy exactly 10*CLKS_PER_BIT cycles after it rose; a new write SHALL be accepted in the cycle busy reads 0.
REQ-027 SHALL hold uart_tx=1 in IDLE.

Reset
REQ-028 SHALL asynchronously clear, while rst=0, gpio_out=0, TIMER=0, CMP=0xFFFF, STATUS=0, UART FSM=IDLE, busy=0, uart_tx=1 and irq=0.
REQ-029 SHALL abort any frame in progress on reset mid-frame, with uart_tx returning to 1 immediately.
REQ-030 SHALL leave RAM contents unreset.
REQ-031 SHALL ignore all strobes while rst=0.

Structure
REQ-032 SHALL keep the address constants and the UART state enum in shared package dmem_pkg.
REQ-033 SHALL put the UART transmitter in sub-module uart_tx (clk, rst, start, data[7:0], busy, tx); decode, RAM, GPIO and timer SHALL stay in dmem_ctrl.

Verification
REQ-034 Bench SHALL cover: store 0x1234 to 0x0010, then load 0x0010 next cycle -> ddin=0x1234 combinationally; load 0x0011 -> also 0x1234.
REQ-035 Bench SHALL cover: load 0x8000 (unmapped) and doe=0 -> ddin=0x0000; store 0xBEEF to 0xFF00 -> gpio_out=0xBEEF next cycle.
REQ-036 Bench SHALL cover: write CMP=0x0005 then TIMER=0x0000 -> irq=1 six cycles later; W1C 0x0001 to STATUS -> irq=0; TIMER 0xFFFF -> 0x0000 wrap.
REQ-037 Bench SHALL cover: CLKS_PER_BIT=4, write UTX 0x0A5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 (4 cycles each); busy for 40 cycles; a second write mid-frame is ignored.
REQ-038 Bench SHALL cover: rst=0 asserted asynchronously mid-frame -> uart_tx=1, busy=0, gpio_out=0 before the next clock edge; RAM retains 0x1234.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared address map and UART state encoding
// for the data-memory controller slice.
package dmem_pkg;

  localparam logic [15:0] A_GPIO   = 16'hFF00;
  localparam logic [15:0] A_TIMER  = 16'hFF02;
  localparam logic [15:0] A_CMP    = 16'hFF04;
  localparam logic [15:0] A_STATUS = 16'hFF06;
  localparam logic [15:0] A_UTX    = 16'hFF08;
  localparam logic [15:0] A_USTAT  = 16'hFF0A;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_st_t;

  // Byte address to even word address; bit 0 never selects.
  function automatic logic [15:0] word_addr(
    input logic [15:0] a
  );
    return {a[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 serial transmitter, LSB first, line idles high.
// busy rises with the start bit and drops after the stop bit.
module uart_tx
  import dmem_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);

  uart_st_t      st;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;

  // Frame sequencer with registered line and busy outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= U_IDLE;
      cnt  <= '0;
      idx  <= '0;
      sh   <= '0;
      busy <= 1'b0;
      tx   <= 1'b1;
    end else begin
      case (st)
        U_IDLE: begin
          if (start) begin
            st   <= U_START;
            cnt  <= '0;
            sh   <= data;
            busy <= 1'b1;
            tx   <= 1'b0;
          end
        end
        U_START: begin
          if (cnt == LAST) begin
            st  <= U_DATA;
            cnt <= '0;
            idx <= '0;
            tx  <= sh[0];
            sh  <= {1'b0, sh[7:1]};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        U_DATA: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (idx == 3'd7) begin
              st <= U_STOP;
              tx <= 1'b1;
            end else begin
              idx <= idx + 3'd1;
              tx  <= sh[0];
              sh  <= {1'b0, sh[7:1]};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        U_STOP: begin
          if (cnt == LAST) begin
            st   <= U_IDLE;
            cnt  <= '0;
            busy <= 1'b0;
            tx   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          st   <= U_IDLE;
          busy <= 1'b0;
          tx   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Core data port: word RAM plus GPIO, free-running
// timer with compare flag, and a UART transmitter.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int RAM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] daddr,
  input  logic [15:0] ddout,
  input  logic        doe,
  input  logic        dwe,
  output logic [15:0] ddin,
  output logic [15:0] gpio_out,
  output logic        uart_tx,
  output logic        irq
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [15:0] ram [RAM_WORDS];
  logic [15:0] timer;
  logic [15:0] cmp;
  logic        match;
  logic        busy;
  logic [15:0] wa;
  logic [AW-1:0] widx;
  logic is_ram, is_gpio, is_timer, is_cmp;
  logic is_status, is_utx, is_ustat;
  logic wr, rd, ram_we, utx_go, clr;

  wire unused_ok = &{1'b0, daddr[0]};

  assign wa     = word_addr(daddr);
  assign widx   = daddr[AW:1];
  assign is_ram = {1'b0, daddr[15:1]} < 16'(RAM_WORDS);
  assign is_gpio   = wa == A_GPIO;
  assign is_timer  = wa == A_TIMER;
  assign is_cmp    = wa == A_CMP;
  assign is_status = wa == A_STATUS;
  assign is_utx    = wa == A_UTX;
  assign is_ustat  = wa == A_USTAT;

  assign wr     = dwe & rst;
  assign rd     = doe & ~dwe;
  assign ram_we = wr & is_ram;
  assign utx_go = wr & is_utx & ~busy;
  assign clr    = wr & is_status & ddout[0];
  assign irq    = match;

  // Zero-latency load mux; unmapped and UTX read as zero
  always_comb begin
    ddin = '0;
    if (rd) begin
      unique case (1'b1)
        is_ram:    ddin = ram[widx];
        is_gpio:   ddin = gpio_out;
        is_timer:  ddin = timer;
        is_cmp:    ddin = cmp;
        is_status: ddin = {15'd0, match};
        is_ustat:  ddin = {15'd0, busy};
        default:   ddin = '0;
      endcase
    end
  end

  // RAM store; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we)
      ram[widx] <= ddout;
  end

  // GPIO and compare registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_out <= '0;
      cmp      <= 16'hFFFF;
    end else begin
      if (wr && is_gpio)
        gpio_out <= ddout;
      if (wr && is_cmp)
        cmp <= ddout;
    end
  end

  // Free-running timer; a store replaces the increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      timer <= '0;
    else if (wr && is_timer)
      timer <= ddout;
    else
      timer <= timer + 16'd1;
  end

  // Sticky match flag; a new match beats a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      match <= 1'b0;
    else
      match <= (timer == cmp) | (match & ~clr);
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rst  (rst),
    .start(utx_go),
    .data (ddout[7:0]),
    .busy (busy),
    .tx   (uart_tx)
  );

endmodule
